// File: rtl/vga_rd_pkg.sv
// Shared types and constants for the VGA frame-buffer read scheduler.
// Contents: scheduler state enum, frame geometry defaults, counter widths
// and the burst-length helper used when sizing each read request.
package vga_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_SPACE,
    REQ,
    XFER
  } state_t;

  localparam int H_DISP_DEF   = 640;
  localparam int V_DISP_DEF   = 480;
  localparam int FRAME_WORDS  = H_DISP_DEF * V_DISP_DEF;
  localparam int FLUSH_CYCLES = 4;
  localparam int REM_W        = 19;
  localparam int LEN_W        = 9;

  // Next burst size: a full burst, or whatever is left of the frame.
  function automatic logic [LEN_W-1:0] next_len(input logic [REM_W-1:0] rem,
                                                input int                max_len);
    if (rem < REM_W'(max_len)) return rem[LEN_W-1:0];
    else                       return LEN_W'(max_len);
  endfunction

endpackage

// File: rtl/vga_underrun_cnt.sv
// Saturating 16-bit event counter for display-side FIFO underruns.
// Ports: clk, rst (sync, active-high), inc (count this cycle), cnt (current value).
// Holds at 16'hFFFF once reached; only reset clears it.
module vga_underrun_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                           cnt <= '0;
    else if (inc && cnt != 16'hFFFF)   cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/vga_rd_sched.sv
// Burst read scheduler keeping the VGA line FIFO filled from SDRAM, restarting on vsync.
// Ports: vga_clk/sys_rst; vga_vs, data_req, fifo_empty, fifo_wr_cnt from the display side;
// fifo_flush to the FIFO; rd_req/rd_addr/rd_len/rd_ack/rd_done to SDRAM; frame_done, underrun_cnt.
module vga_rd_sched
  import vga_rd_pkg::*;
#(
  parameter int                H_DISP     = H_DISP_DEF,
  parameter int                V_DISP     = V_DISP_DEF,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 1024,
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              vga_vs,
  input  logic              data_req,
  input  logic              fifo_empty,
  input  logic [10:0]       fifo_wr_cnt,
  output logic              fifo_flush,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              frame_done,
  output logic [15:0]       underrun_cnt
);

  localparam logic [REM_W-1:0] FRAME_LEN  = REM_W'(H_DISP * V_DISP);
  localparam logic [1:0]       FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t             state, state_nxt;
  logic               vs_d, vs_fall;
  logic [1:0]         flush_cnt, flush_cnt_nxt;
  logic               pend_vs, pend_vs_nxt;
  logic               done_early, done_early_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [LEN_W-1:0]   len_nxt;
  logic [REM_W-1:0]   remaining, rem_nxt, rem_after;
  logic               frame_done_nxt;
  logic [11:0]        space_sum;
  logic               space_ok;
  logic               xfer_done;

  assign vs_fall    = vs_d & ~vga_vs;
  assign space_sum  = {1'b0, fifo_wr_cnt} + 12'(BURST_LEN);
  assign space_ok   = (space_sum <= 12'(FIFO_DEPTH));
  assign rem_after  = remaining - REM_W'(rd_len);
  // An rd_done that arrived together with rd_ack is remembered in done_early
  // so the first XFER cycle already takes the exit decision.
  assign xfer_done  = rd_done | done_early;

  assign fifo_flush = (state == FLUSH);
  assign rd_req     = (state == REQ);

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    pend_vs_nxt    = pend_vs;
    done_early_nxt = done_early;
    addr_nxt       = rd_addr;
    len_nxt        = rd_len;
    rem_nxt        = remaining;
    frame_done_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (vs_fall) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end
      end

      FLUSH: begin
        addr_nxt       = FRAME_BASE;
        rem_nxt        = FRAME_LEN;
        pend_vs_nxt    = 1'b0;
        done_early_nxt = 1'b0;
        // A new vsync during the flush restarts the full flush window.
        if (vs_fall)                      flush_cnt_nxt = '0;
        else if (flush_cnt == FLUSH_LAST) state_nxt     = WAIT_SPACE;
        else                              flush_cnt_nxt = flush_cnt + 2'd1;
      end

      WAIT_SPACE: begin
        if (vs_fall) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end else if (space_ok) begin
          len_nxt   = next_len(remaining, BURST_LEN);
          state_nxt = REQ;
        end
      end

      REQ: begin
        if (vs_fall) pend_vs_nxt = 1'b1;
        if (rd_ack) begin
          state_nxt      = XFER;
          done_early_nxt = rd_done;
        end
      end

      XFER: begin
        if (vs_fall) pend_vs_nxt = 1'b1;
        if (xfer_done) begin
          done_early_nxt = 1'b0;
          addr_nxt       = rd_addr + ADDR_W'(rd_len);
          rem_nxt        = rem_after;
          if (pend_vs || vs_fall) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = '0;
            pend_vs_nxt   = 1'b0;
          end else if (rem_after == '0) begin
            frame_done_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            state_nxt = WAIT_SPACE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      vs_d       <= 1'b1;
      flush_cnt  <= '0;
      pend_vs    <= 1'b0;
      done_early <= 1'b0;
      rd_addr    <= FRAME_BASE;
      rd_len     <= '0;
      remaining  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_d       <= vga_vs;
      flush_cnt  <= flush_cnt_nxt;
      pend_vs    <= pend_vs_nxt;
      done_early <= done_early_nxt;
      rd_addr    <= addr_nxt;
      rd_len     <= len_nxt;
      remaining  <= rem_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  vga_underrun_cnt u_underrun (
    .clk (vga_clk),
    .rst (sys_rst),
    .inc (data_req & fifo_empty),
    .cnt (underrun_cnt)
  );

endmodule

// File: tb/tb_vga_rd_sched.sv
// Directed bench for vga_rd_sched: reset values, vsync-to-request latency, FIFO space
// threshold, ack hold, vsync during transfer, full frame, underrun table and saturation.
module tb_vga_rd_sched;
  import vga_rd_pkg::*;

  logic        vga_clk = 1'b0;
  logic        sys_rst, vga_vs, data_req, fifo_empty;
  logic [10:0] fifo_wr_cnt;
  logic        fifo_flush, rd_req, rd_ack, rd_done, frame_done;
  logic [23:0] rd_addr;
  logic [8:0]  rd_len;
  logic [15:0] underrun_cnt;

  logic ctl_ack = 1'b0, ctl_done = 1'b0, man_ack = 1'b0, man_done = 1'b0;
  logic ctl_en = 1'b0;
  int   ack_delay = 0, done_delay = 0;
  int   checks = 0, failures = 0;

  assign rd_ack  = ctl_ack | man_ack;
  assign rd_done = ctl_done | man_done;

  always #5 vga_clk = ~vga_clk;

  vga_rd_sched dut (
    .vga_clk      (vga_clk),
    .sys_rst      (sys_rst),
    .vga_vs       (vga_vs),
    .data_req     (data_req),
    .fifo_empty   (fifo_empty),
    .fifo_wr_cnt  (fifo_wr_cnt),
    .fifo_flush   (fifo_flush),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_done      (rd_done),
    .frame_done   (frame_done),
    .underrun_cnt (underrun_cnt)
  );

  // SDRAM controller model: ack after ack_delay cycles, rd_done done_delay cycles after ack
  // (done_delay=0 gives ack and done in the same cycle).
  initial begin
    forever begin
      @(negedge vga_clk);
      if (ctl_en && rd_req === 1'b1) begin
        repeat (ack_delay) @(negedge vga_clk);
        ctl_ack  = 1'b1;
        ctl_done = (done_delay == 0);
        @(negedge vga_clk);
        ctl_ack  = 1'b0;
        ctl_done = 1'b0;
        if (done_delay > 0) begin
          repeat (done_delay - 1) @(negedge vga_clk);
          ctl_done = 1'b1;
          @(negedge vga_clk);
          ctl_done = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input int max_cyc, input string name);
    int n;
    n = 0;
    while (rd_req !== lvl && n < max_cyc) begin
      @(negedge vga_clk);
      n++;
    end
    if (rd_req !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for rd_req=%0b", name, lvl);
    end
  endtask

  // Long reset also lets any in-flight controller sequence drain.
  task automatic do_reset();
    ctl_en      = 1'b0;
    sys_rst     = 1'b1;
    vga_vs      = 1'b1;
    data_req    = 1'b0;
    fifo_empty  = 1'b0;
    fifo_wr_cnt = '0;
    man_ack     = 1'b0;
    man_done    = 1'b0;
    repeat (80) @(negedge vga_clk);
    sys_rst = 1'b0;
  endtask

  typedef struct {
    logic [10:0] cnt;
    logic        exp_req;
  } space_vec_t;

  typedef struct {
    logic        req;
    logic        empty;
    logic [15:0] exp_cnt;
  } urun_vec_t;

  initial begin
    space_vec_t  sv[6];
    urun_vec_t   uv[6];
    int          fl_n, fl_first, rq_first, fd_n, n, bad, cyc, n_req, post;
    logic        got, prev;
    logic [23:0] a_cap, last_addr;
    logic [8:0]  l_cap;

    sv[0] = '{11'd0,    1'b1};
    sv[1] = '{11'd960,  1'b1};
    sv[2] = '{11'd1024, 1'b0};
    sv[3] = '{11'd2047, 1'b0};
    sv[4] = '{11'd100,  1'b1};
    sv[5] = '{11'd961,  1'b0};

    uv[0] = '{1'b1, 1'b1, 16'd1};
    uv[1] = '{1'b1, 1'b0, 16'd1};
    uv[2] = '{1'b0, 1'b1, 16'd1};
    uv[3] = '{1'b1, 1'b1, 16'd2};
    uv[4] = '{1'b1, 1'b1, 16'd3};
    uv[5] = '{1'b0, 1'b0, 16'd3};

    // Reset state
    do_reset();
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_fifo_flush", 32'(fifo_flush), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));

    // Vsync to first request latency, flush width, second burst address
    ack_delay = 2; done_delay = 70; ctl_en = 1'b1;
    vga_vs = 1'b0;
    fl_n = 0; fl_first = -1; rq_first = -1; a_cap = '1; l_cap = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge vga_clk);
      if (fifo_flush) begin
        fl_n++;
        if (fl_first < 0) fl_first = i;
      end
      if (rd_req && rq_first < 0) begin
        rq_first = i; a_cap = rd_addr; l_cap = rd_len;
      end
    end
    chk("t1_flush_cycles", 32'(fl_n), 32'd4);
    chk("t1_flush_start", 32'(fl_first), 32'd1);
    chk("t1_first_req_cycle", 32'(rq_first), 32'd6);
    chk("t1_first_addr", 32'(a_cap), 32'd0);
    chk("t1_first_len", 32'(l_cap), 32'd64);
    wait_req(1'b0, 20, "t1_ack");
    wait_req(1'b1, 200, "t1_second_req");
    chk("t1_second_addr", 32'(rd_addr), 32'd64);
    chk("t1_second_len", 32'(rd_len), 32'd64);

    // FIFO space threshold table (no controller: a request just stays pending)
    for (int k = 0; k < 6; k++) begin
      do_reset();
      fifo_wr_cnt = sv[k].cnt;
      vga_vs = 1'b0;
      repeat (10) @(negedge vga_clk);
      chk($sformatf("space_req_cnt%0d", sv[k].cnt), 32'(rd_req), 32'(sv[k].exp_req));
    end
    fifo_wr_cnt = 11'd960;
    @(negedge vga_clk);
    chk("space_drop_to_960", 32'(rd_req), 32'd1);

    // Slow ack: request held stable, drops the cycle after ack
    do_reset();
    vga_vs = 1'b0;
    wait_req(1'b1, 20, "t4_req");
    a_cap = rd_addr; l_cap = rd_len; bad = 0;
    repeat (50) begin
      @(negedge vga_clk);
      if (rd_req !== 1'b1 || rd_addr !== a_cap || rd_len !== l_cap) bad++;
    end
    chk("t4_hold_glitches", 32'(bad), 32'd0);
    chk("t4_held_len", 32'(l_cap), 32'd64);
    man_ack = 1'b1;
    @(negedge vga_clk);
    man_ack = 1'b0;
    chk("t4_req_after_ack", 32'(rd_req), 32'd0);
    @(negedge vga_clk);
    man_done = 1'b1;
    @(negedge vga_clk);
    man_done = 1'b0;
    wait_req(1'b1, 10, "t4_next_req");
    chk("t4_next_addr", 32'(rd_addr), 32'd64);

    // Vsync during the transfer of the burst at 1280
    do_reset();
    ack_delay = 0; done_delay = 10; ctl_en = 1'b1;
    vga_vs = 1'b0;
    repeat (3) @(negedge vga_clk);
    vga_vs = 1'b1;
    n = 0;
    while (!(rd_req === 1'b1 && rd_addr === 24'd1280) && n < 2000) begin
      @(negedge vga_clk);
      n++;
    end
    chk("t5_reached_1280", 32'(rd_addr), 32'd1280);
    wait_req(1'b0, 5, "t5_ack");
    vga_vs = 1'b0;
    fl_n = 0; fl_first = -1; fd_n = 0; got = 1'b0; a_cap = '1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge vga_clk);
      if (fifo_flush) begin
        fl_n++;
        if (fl_first < 0) fl_first = i;
      end
      if (frame_done) fd_n++;
      if (rd_req && !got) begin
        got = 1'b1; a_cap = rd_addr;
      end
    end
    chk("t5_flush_cycles", 32'(fl_n), 32'd4);
    chk("t5_flush_after_done", 32'(fl_first), 32'd10);
    chk("t5_frame_done_cnt", 32'(fd_n), 32'd0);
    chk("t5_new_req_seen", 32'(got), 32'd1);
    chk("t5_restart_addr", 32'(a_cap), 32'd0);

    // Underrun counter table
    do_reset();
    for (int k = 0; k < 6; k++) begin
      data_req = uv[k].req; fifo_empty = uv[k].empty;
      @(negedge vga_clk);
      chk($sformatf("urun_vec%0d", k), 32'(underrun_cnt), 32'(uv[k].exp_cnt));
    end

    // Full frame with ideal controller (ack+done together) while underruns accumulate
    do_reset();
    ack_delay = 0; done_delay = 0; ctl_en = 1'b1;
    data_req = 1'b1; fifo_empty = 1'b1;
    vga_vs = 1'b0;
    cyc = 0; n_req = 0; prev = 1'b0; fd_n = 0; post = 0; last_addr = '1;
    while (cyc < 20000 && post < 5) begin
      @(negedge vga_clk);
      cyc++;
      if (rd_req && !prev) begin
        n_req++; last_addr = rd_addr;
      end
      prev = rd_req;
      if (frame_done) fd_n++;
      if (fd_n > 0) post++;
    end
    chk("t2_requests", 32'(n_req), 32'd4800);
    chk("t2_last_addr", 32'(last_addr), 32'(FRAME_WORDS - 64));
    chk("t2_frame_done_pulses", 32'(fd_n), 32'd1);
    chk("t2_state_idle", 32'(dut.state), 32'(IDLE));
    chk("t6_underrun_midway", 32'(underrun_cnt), 32'(cyc));
    while (cyc < 65534) begin
      @(negedge vga_clk);
      cyc++;
    end
    chk("t6_underrun_65534", 32'(underrun_cnt), 32'hFFFE);
    while (cyc < 70000) begin
      @(negedge vga_clk);
      cyc++;
    end
    chk("t6_underrun_sat", 32'(underrun_cnt), 32'hFFFF);
    repeat (10) @(negedge vga_clk);
    chk("t6_underrun_hold", 32'(underrun_cnt), 32'hFFFF);
    sys_rst = 1'b1;
    @(negedge vga_clk);
    sys_rst = 1'b0;
    chk("t6_rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("t6_rst_rd_req", 32'(rd_req), 32'd0);
    chk("t6_rst_state", 32'(dut.state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_rd_sched.md
Name: vga_rd_sched

Overview:
Read scheduler feeding the VGA pixel path from the SDRAM frame buffer. Each frame it issues burst read requests to the SDRAM read port so the line FIFO stays ahead of the VGA driver's data_req. It restarts cleanly at every vertical sync and counts FIFO underruns seen by the display side. It sits between the SDRAM controller read port, the read-side line FIFO and the 640x480 VGA driver.

Parameters:
H_DISP, 640, active pixels per line
V_DISP, 480, active lines per frame
BURST_LEN, 64, maximum words per read burst (1..256)
FIFO_DEPTH, 1024, line FIFO capacity in 16-bit words
ADDR_W, 24, SDRAM word-address width
FRAME_BASE, 0, word address of pixel (0,0)

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
sys_rst  in  1  synchronous reset, active-high
vga_vs  in  1  VGA field sync from the driver, active-low
data_req  in  1  VGA driver pixel request; the FIFO is popped on this cycle
fifo_empty  in  1  line FIFO empty flag
fifo_wr_cnt  in  11  words currently in the line FIFO
fifo_flush  out  1  clear line FIFO
rd_req  out  1  burst read request to the SDRAM controller
rd_addr  out  ADDR_W  burst start word address
rd_len  out  9  burst length in words (1..256)
rd_ack  in  1  SDRAM controller accepts the request
rd_done  in  1  one-cycle pulse: last word of the burst has been written into the FIFO
frame_done  out  1  one-cycle pulse: all H_DISP*V_DISP words have been requested and completed
underrun_cnt  out  16  saturating count of cycles where data_req=1 and fifo_empty=1

Behaviour:
- Reset (sys_rst=1 at a clock edge): state IDLE. rd_req=0, rd_addr=FRAME_BASE, rd_len=0, fifo_flush=0, frame_done=0, underrun_cnt=0, remaining=0, pend_vs=0. The vs history register is set to 1.
- Frame start: vs_fall = vs_d & ~vga_vs, where vs_d is vga_vs registered once.
- Counters: remaining is 19 bits and loads H_DISP*V_DISP (307200). The address adds rd_len modulo 2^ADDR_W.
- States:
  - IDLE: on vs_fall, go to FLUSH.
  - FLUSH: hold fifo_flush=1 for exactly 4 cycles. Load rd_addr=FRAME_BASE and remaining=H_DISP*V_DISP. Then go to WAIT_SPACE.
  - WAIT_SPACE: when fifo_wr_cnt + BURST_LEN <= FIFO_DEPTH (evaluated at 12-bit width), set rd_len=min(BURST_LEN, remaining). Assert rd_req on the next cycle and go to REQ.
  - REQ: hold rd_req=1 with rd_addr and rd_len stable until rd_ack=1 is sampled. Deassert rd_req the cycle after the ack and go to XFER. The request is never withdrawn before it is acked.
  - XFER: wait for rd_done. Then rd_addr += rd_len and remaining -= rd_len.
    - If pend_vs=1: go to FLUSH and clear pend_vs.
    - Else if remaining reaches 0: pulse frame_done for 1 cycle and go to IDLE.
    - Else: go to WAIT_SPACE.
- vs_fall in WAIT_SPACE: go to FLUSH immediately, with no request issued.
- vs_fall in REQ or XFER: set pend_vs. The accepted or pending burst completes, then the block restarts from FLUSH. No frame_done is pulsed in this case.
- vs_fall in FLUSH: restart the 4-cycle flush count.
- rd_ack and rd_done arriving in the same cycle while in REQ: treat as ack then done; go directly to the XFER-exit decision in the next cycle.
- rd_done outside XFER: ignored.
- Last burst: rd_len = remaining when remaining < BURST_LEN. Example: 307200 mod 64 = 0, so all 4800 bursts are 64 words.
- underrun_cnt: increments when data_req & fifo_empty, saturates at 16'hFFFF. Cleared only by reset.
- Latency: the first rd_req is asserted 6 cycles after the vga_vs falling edge (1 cycle detect, 4 cycles flush, 1 cycle WAIT_SPACE), assuming the FIFO has space.

Decomposition:
- Package vga_rd_pkg:
  - state enum {IDLE, FLUSH, WAIT_SPACE, REQ, XFER}
  - FRAME_WORDS = H_DISP*V_DISP
  - FLUSH_CYCLES = 4
  - widths REM_W=19, LEN_W=9
- Sub-module: vga_underrun_cnt, a 16-bit saturating event counter with synchronous active-high reset. Everything else stays in a single FSM module.

Test Plan:
1. Reset, then drive vga_vs 1->0 with fifo_wr_cnt=0 and a controller model that acks after 2 cycles and pulses rd_done 70 cycles later -> fifo_flush high for exactly 4 cycles; first rd_req 6 cycles after the edge with rd_addr=0 and rd_len=64; second request has rd_addr=64.
2. Full frame with an ideal controller -> exactly 4800 requests; last rd_addr=307136; one frame_done pulse; state returns to IDLE.
3. Hold fifo_wr_cnt=961 -> no rd_req. Drop fifo_wr_cnt to 960 -> rd_req asserts 1 cycle later.
4. Delay rd_ack by 50 cycles -> rd_req, rd_addr and rd_len are held constant throughout; rd_req deasserts the cycle after the ack.
5. vga_vs falls during XFER of the burst at address 1280 -> burst completes; 4-cycle flush; next rd_addr=0; no frame_done.
6. Force fifo_empty=1 with data_req=1 for 70000 cycles -> underrun_cnt=16'hFFFF and holds. sys_rst=1 for 1 cycle -> underrun_cnt=0, rd_req=0, state IDLE.
